// File: rtl/move_cmd_arbiter.sv
// move_cmd_arbiter
//   Round-robin arbiter for two timed movement requesters. The granted
//   direction is held on the 4-bit bus {oDATA_X, oDATA_Y} for a set number
//   of frame ticks. The bus then returns to the stop code (0000) and a
//   one-cycle completion pulse is issued.
//
// Ports
//   iCLK, iRSTn          clock / asynchronous active-low reset
//   iREQ0/1              level requests, held until acked
//   iDIR0/1  [3:0]       {x_en, x_right, y_en, y_up}
//   iSTEPS0/1[STEP_W]    number of frame ticks to hold the direction
//   iABORT               terminate the running command (RUN only)
//   oACK0/1              one-cycle accept pulse
//   oDATA_X  [1:0]       {x_en, x_right}
//   oDATA_Y  [1:0]       {y_en, y_up}
//   oBUSY                high while a command is running or completing
//   oOWNER               index of the current / last granted requester
//   oDONE                one-cycle completion pulse (normal end or abort)
//   oTICK                one-cycle frame-tick pulse
module move_cmd_arbiter #(
  parameter int TICK_DIV = 416667,
  parameter int STEP_W   = 8
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iREQ0,
  input  logic              iREQ1,
  input  logic [3:0]        iDIR0,
  input  logic [3:0]        iDIR1,
  input  logic [STEP_W-1:0] iSTEPS0,
  input  logic [STEP_W-1:0] iSTEPS1,
  input  logic              iABORT,
  output logic              oACK0,
  output logic              oACK1,
  output logic [1:0]        oDATA_X,
  output logic [1:0]        oDATA_Y,
  output logic              oBUSY,
  output logic              oOWNER,
  output logic              oDONE,
  output logic              oTICK
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [CNT_W-1:0]  tick_cnt_reg, tick_cnt_next;
  logic              tick_reg;
  state_t            state_reg, state_next;
  logic              ptr_reg, ptr_next;
  logic [STEP_W-1:0] remaining_reg, remaining_next;
  logic [3:0]        bus_reg, bus_next;
  logic              owner_reg, owner_next;
  logic              ack0_reg, ack0_next;
  logic              ack1_reg, ack1_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              grant_sel;
  logic [3:0]        dir_sel;
  logic [STEP_W-1:0] steps_sel;

  // Free-running frame tick. The flag is registered from the next count so
  // it is high exactly while the counter holds TICK_DIV-1.
  always_comb begin
    tick_cnt_next = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      tick_cnt_reg <= '0;
      tick_reg     <= 1'b0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      tick_reg     <= (tick_cnt_next == TICK_LAST);
    end
  end

  // A lone request wins outright; a tie goes to the priority pointer.
  always_comb begin
    grant_sel = (iREQ0 && iREQ1) ? ptr_reg : iREQ1;
    dir_sel   = grant_sel ? iDIR1   : iDIR0;
    steps_sel = grant_sel ? iSTEPS1 : iSTEPS0;
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    bus_next       = bus_reg;
    owner_next     = owner_reg;
    busy_next      = busy_reg;
    ack0_next      = 1'b0;
    ack1_next      = 1'b0;
    done_next      = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (iREQ0 || iREQ1) begin
          ack0_next      = ~grant_sel;
          ack1_next      = grant_sel;
          owner_next     = grant_sel;
          ptr_next       = ~grant_sel;
          remaining_next = steps_sel;
          busy_next      = 1'b1;
          state_next     = S_RUN;
          // A zero-step command spends its ack cycle with the bus stopped
          // and completes on the following edge without ever moving.
          bus_next       = (steps_sel == '0) ? 4'b0000 : dir_sel;
        end
      end

      S_RUN: begin
        // Abort outranks a coincident tick: remaining is left untouched.
        if (iABORT || (remaining_reg == '0)) begin
          bus_next   = 4'b0000;
          done_next  = 1'b1;
          state_next = S_DONE;
        end else if (tick_reg) begin
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == STEP_W'(1)) begin
            bus_next   = 4'b0000;
            done_next  = 1'b1;
            state_next = S_DONE;
          end
        end
      end

      S_DONE: begin
        bus_next   = 4'b0000;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end

      default: begin
        bus_next   = 4'b0000;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= 1'b0;
      remaining_reg <= '0;
      bus_reg       <= 4'b0000;
      owner_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      bus_reg       <= bus_next;
      owner_reg     <= owner_next;
      busy_reg      <= busy_next;
      ack0_reg      <= ack0_next;
      ack1_reg      <= ack1_next;
      done_reg      <= done_next;
    end
  end

  assign oACK0   = ack0_reg;
  assign oACK1   = ack1_reg;
  assign oDATA_X = bus_reg[3:2];
  assign oDATA_Y = bus_reg[1:0];
  assign oBUSY   = busy_reg;
  assign oOWNER  = owner_reg;
  assign oDONE   = done_reg;
  assign oTICK   = tick_reg;

endmodule

// File: tb/tb_move_cmd_arbiter.sv
module tb_move_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req0, req1, abort_in;
  logic [3:0] dir0, dir1;
  logic [7:0] steps0, steps1;
  logic       ack0, ack1, busy, owner, done, tick;
  logic [1:0] data_x, data_y;
  logic [3:0] bus;

  assign bus = {data_x, data_y};

  always #5 clk = ~clk;

  move_cmd_arbiter #(.TICK_DIV(4), .STEP_W(8)) dut (
    .iCLK(clk), .iRSTn(rstn),
    .iREQ0(req0), .iREQ1(req1),
    .iDIR0(dir0), .iDIR1(dir1),
    .iSTEPS0(steps0), .iSTEPS1(steps1),
    .iABORT(abort_in),
    .oACK0(ack0), .oACK1(ack1),
    .oDATA_X(data_x), .oDATA_Y(data_y),
    .oBUSY(busy), .oOWNER(owner), .oDONE(done), .oTICK(tick)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: who should be granted, what the bus should carry,
  // and how many ticks should be seen with that direction on the bus.
  typedef struct {
    logic       own;
    logic [3:0] dir;
    int         ticks;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   active = 0;
  bit   bus_dev = 0;
  int   tick_cnt = 0;

  function automatic exp_t mk(input logic o, input logic [3:0] d, input int t);
    exp_t e;
    e.own = o; e.dir = d; e.ticks = t;
    return e;
  endfunction

  // Monitor: pops the expected command at each ack, follows the bus and
  // the ticks, and compares at the completion pulse.
  always @(negedge clk) begin
    if (!rstn) begin
      active = 0;
    end else begin
      if (ack0 || ack1) begin
        chk("ack_onehot", {31'd0, ack0 & ack1}, 0);
        chk("ack_queued", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("ack_owner", {31'd0, ack1}, {31'd0, cur.own});
          chk("owner_at_ack", {31'd0, owner}, {31'd0, cur.own});
          chk("bus_at_ack", {28'd0, bus}, {28'd0, cur.dir});
          chk("busy_at_ack", {31'd0, busy}, 1);
          active = 1;
          tick_cnt = 0;
          bus_dev = 0;
        end
      end
      if (active) begin
        if (!done && bus != cur.dir) bus_dev = 1;
        if (tick && cur.dir != 4'b0000 && bus == cur.dir) tick_cnt++;
        if (done) begin
          chk("ticks_with_dir", tick_cnt, cur.ticks);
          chk("bus_at_done", {28'd0, bus}, 0);
          chk("owner_at_done", {31'd0, owner}, {31'd0, cur.own});
          chk("bus_steady", {31'd0, bus_dev}, 0);
          $display("TXN owner=%0d dir=%b ticks=%0d t=%0t", cur.own, cur.dir, tick_cnt, $time);
          active = 0;
        end
      end else begin
        chk("spurious_done", {31'd0, done}, 0);
      end
    end
  end

  // which: 0 ack0, 1 ack1, 2 done, 3 tick, other: any ack
  task automatic wait_sig(input int which, input int limit, input string tag, output int at);
    bit hit;
    hit = 0;
    at = -1;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = ack0;
        1: hit = ack1;
        2: hit = done;
        3: hit = tick;
        default: hit = ack0 | ack1;
      endcase
      if (hit) at = cyc;
    end
    if (!hit) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a1, a2, d1, t1, t2, n, g;
    rstn = 0; req0 = 0; req1 = 0; abort_in = 0;
    dir0 = 0; dir1 = 0; steps0 = 0; steps1 = 0;

    #1;
    chk("reset_outputs", {22'd0, ack0, ack1, data_x, data_y, busy, owner, done, tick}, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1;

    // Single command: dir 1110 for 3 ticks.
    exp_q.push_back(mk(1'b0, 4'b1110, 3));
    dir0 = 4'b1110; steps0 = 8'd3; req0 = 1;
    c0 = cyc;
    wait_sig(0, 20, "single_ack", a1);
    req0 = 0;
    dir0 = 4'b0001; steps0 = 8'd0;   // post-ack changes must not matter
    chk("grant_latency", a1 - c0, 1);
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, ack0}, 0);
    wait_sig(2, 100, "single_done", d1);
    @(negedge clk);
    chk("single_idle_busy", {31'd0, busy}, 0);
    chk("single_owner_kept", {31'd0, owner}, 0);
    wait_sig(3, 20, "tick_a", t1);
    wait_sig(3, 20, "tick_b", t2);
    chk("tick_period", t2 - t1, 4);

    // Zero steps on requester 1: ack then done, no motion.
    exp_q.push_back(mk(1'b1, 4'b0000, 0));
    dir1 = 4'b0101; steps1 = 8'd0; req1 = 1;
    wait_sig(1, 20, "zero_ack", a1);
    req1 = 0;
    @(negedge clk);
    chk("zero_done_next", {31'd0, done}, 1);
    chk("zero_bus", {28'd0, bus}, 0);
    @(negedge clk);
    chk("zero_idle_busy", {31'd0, busy}, 0);

    // Abort on the third tick of a 10-step command.
    exp_q.push_back(mk(1'b0, 4'b1001, 3));
    dir0 = 4'b1001; steps0 = 8'd10; req0 = 1;
    wait_sig(0, 20, "abort_ack", a1);
    req0 = 0;
    n = tick ? 1 : 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (tick) n++;
    end
    chk("abort_tick_found", n, 3);
    abort_in = 1;
    @(negedge clk);
    abort_in = 0;
    chk("abort_done", {31'd0, done}, 1);
    chk("abort_bus", {28'd0, bus}, 0);
    chk("abort_busy_done", {31'd0, busy}, 1);
    chk("abort_remaining", {24'd0, dut.remaining_reg}, 8);
    @(negedge clk);
    chk("abort_busy_idle", {31'd0, busy}, 0);

    // Held request, with abort asserted in IDLE alongside the first grant.
    exp_q.push_back(mk(1'b0, 4'b0110, 1));
    exp_q.push_back(mk(1'b0, 4'b0110, 1));
    dir0 = 4'b0110; steps0 = 8'd1; req0 = 1; abort_in = 1;
    wait_sig(0, 20, "held_ack1", a1);
    abort_in = 0;
    wait_sig(2, 40, "held_done1", d1);
    wait_sig(0, 20, "held_ack2", a2);
    req0 = 0;
    chk("held_regrant_spacing", a2 - d1, 2);
    wait_sig(2, 40, "held_done2", d1);
    @(negedge clk);

    // Reset in the middle of a run.
    exp_q.push_back(mk(1'b0, 4'b1010, 10));
    dir0 = 4'b1010; steps0 = 8'd10; req0 = 1;
    wait_sig(0, 20, "rst_ack", a1);
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_running_bus", {28'd0, bus}, 4'b1010);
    #2;
    rstn = 0;
    #1;
    chk("rst_async_outputs", {22'd0, ack0, ack1, data_x, data_y, busy, owner, done, tick}, 0);

    // Both requests from reset: grants must alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) exp_q.push_back(k[0] ? mk(1'b1, 4'b0011, 1) : mk(1'b0, 4'b1100, 2));
    dir0 = 4'b1100; steps0 = 8'd2; dir1 = 4'b0011; steps1 = 8'd1;
    req0 = 1; req1 = 1;
    @(negedge clk);
    chk("rst_no_done", {31'd0, done}, 0);
    @(negedge clk);
    rstn = 1;
    for (g = 0; g < 4; g++) begin
      wait_sig(4, 60, "rr_ack", a1);
      chk("rr_order", {31'd0, ack1}, g % 2);
      if (g == 3) begin
        req0 = 0; req1 = 0;
      end else begin
        if (ack0) req0 = 0; else req1 = 0;
        @(negedge clk);
        req0 = 1; req1 = 1;
      end
    end
    wait_sig(2, 40, "rr_done", d1);
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_idle", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_cmd_arbiter.md
# move_cmd_arbiter

Arbitrates timed movement commands from two requesters (e.g. joystick decoder and UART command parser) onto the single 4-bit direction bus `{data_x, data_y}` that drives the on-screen square's position updater. Each command is a direction code plus a step count. The block grants one requester at a time, round-robin, and holds the granted direction on the bus for that many frame ticks. It then returns the bus to the stop code and signals completion.

## Interface
Parameters:
- `TICK_DIV`, default 416667: iCLK cycles per frame tick; one tick per ~60 Hz frame at 25 MHz.
- `STEP_W`, default 8: width of the step-count fields.

Ports:
- `iCLK`  in  1  clock; 25 MHz pixel-clock domain.
- `iRSTn`  in  1  reset; asynchronous, active-low.
- `iREQ0` / `iREQ1`  in  1  request from requester 0 / 1; level, held until acked.
- `iDIR0` / `iDIR1`  in  4  direction code `{x_en, x_right, y_en, y_up}`; `x_en=0` and `y_en=0` means no motion on that axis.
- `iSTEPS0` / `iSTEPS1`  in  STEP_W  number of ticks to hold the direction.
- `iABORT`  in  1  terminate the running command.
- `oACK0` / `oACK1`  out  1  one-cycle accept pulse.
- `oDATA_X`  out  2  `{x_en, x_right}` to the position updater.
- `oDATA_Y`  out  2  `{y_en, y_up}` to the position updater.
- `oBUSY`  out  1  high in RUN and DONE.
- `oOWNER`  out  1  index of the current or last granted requester.
- `oDONE`  out  1  one-cycle completion pulse; normal end or abort.
- `oTICK`  out  1  one-cycle frame-tick pulse, for alignment and debugging.

## Operation
- Tick counter: free-running 0..TICK_DIV-1. `oTICK=1` in the cycle the counter equals TICK_DIV-1. The counter is never reset by commands.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - Samples requests. If exactly one `iREQn=1`, that requester is granted.
  - If both are high, the requester selected by the priority pointer `ptr` is granted.
  - On grant: `oACKn=1` for one cycle, latch dir and steps, set `oOWNER=n`, set `ptr=~n`, go to RUN.
  - If the latched steps equal 0, go to DONE instead and never drive motion.
- RUN:
  - `{oDATA_X, oDATA_Y}` = latched dir.
  - On each tick, `remaining` decrements. The tick coinciding with the first RUN cycle counts.
  - When `remaining` goes 1→0, go to DONE.
- DONE: `{oDATA_X, oDATA_Y}=0000`, `oDONE=1` for exactly one cycle, then IDLE.
- Abort:
  - `iABORT=1` in RUN → DONE on the next edge. Abort has priority over a tick in the same cycle.
  - `iABORT` is ignored in IDLE and DONE. Abort together with a request in IDLE: the request is granted.
- Requester rule: drop `iREQn` the cycle after `oACKn`. A request still high on return to IDLE is a new command.
- Changes to `iDIRn`/`iSTEPSn` after ack have no effect.
- The direction code is passed through unmodified; `00?? / ??00` codes simply produce no motion on that axis.
- Reset values:
  - All outputs 0, including `oDATA_X` = `oDATA_Y` = 00.
  - `ptr=0`, tick counter 0, `remaining=0`, state IDLE.
- Reset mid-RUN drops the bus to 0000 immediately (asynchronous). No `oDONE` is issued.

## Timing
- Request high at edge k in IDLE → at edge k+1: ack high, `oBUSY=1`, and `oDATA` = dir. Grant latency is 1 cycle.
- `oDATA` holds dir from the grant edge until the edge after the tick that consumes the last step.
  - Exactly `steps` ticks are observed with dir on the bus.
- DONE lasts 1 cycle. The earliest next grant comes one cycle after DONE. Minimum spacing between acks is 3 cycles when steps ≥ 1 and the tick lands immediately.
- All outputs are registered. No combinational path runs from inputs to outputs.
- `remaining` width is STEP_W. The maximum of 2^STEP_W-1 steps has no wrap.

## Test plan
- Single command (TICK_DIV=4):
  - Stimulus: `iREQ0`, dir 1110, steps 3.
  - Response: `oACK0` one cycle later, `oDATA` = 11/10 for exactly 3 `oTICK` pulses, then 0000, a single `oDONE`, and `oOWNER=0`.
- Simultaneous requests:
  - Stimulus: `iREQ0` and `iREQ1` both high from reset, with each requester re-asserting after its ack.
  - Response: grants go 0, 1, 0, 1, and `ptr` alternates.
- Zero steps:
  - Stimulus: `iREQ1` with steps 0.
  - Response: `oACK1`, the next cycle `oDONE`, and `oDATA` never leaves 0000.
- Abort:
  - Stimulus: steps 10, with `iABORT` asserted after 2 ticks, in the same cycle as a tick.
  - Response: bus 0000 and `oDONE` the next cycle, `oBUSY=0` one cycle later, and `remaining` is not decremented by that tick.
- Held request:
  - Stimulus: `iREQ0` held high through the whole command.
  - Response: a second grant to requester 0 the cycle after DONE, with a new ack.
- Reset:
  - Stimulus: assert `iRSTn=0` mid-RUN.
  - Response: all outputs 0 asynchronously. After release, the first request is granted with `ptr=0` priority.
